// File: rtl/rc4_key_engine.sv
// ---------------------------------------------------------------------------
// rc4_key_engine
//
// A single RC4 engine that processes one key per start/done handshake. A run
// has three phases:
//   INIT    : writes s[n] = n for n = 0..255.
//   SHUFFLE : runs the key schedule, 6 cycles per i.
//   DECRYPT : produces the keystream and decodes MSG_LEN bytes, 8 cycles per
//             byte.
// When CHECK_EN is set, each decoded byte is graded. The run stops at the
// first byte that is not lowercase a-z or space, so a key-search controller
// above this engine can reject a key early.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      begins a run; sampled only while idle
//   key        secret key, byte 0 in the top 8 bits; hold stable while busy
//   busy       high from the first INIT cycle through the DONE cycle
//   done       one-cycle pulse at the end of a run
//   key_valid  result of the last run; held until the next accepted start
//   s_addr / s_data / s_wren / s_q
//              S-memory port (synchronous read, one wait cycle)
//   rom_addr / rom_q
//              encrypted-message ROM (same timing as the S-memory)
//   res_addr / res_data / res_wren
//              decoded-message RAM write port
// ---------------------------------------------------------------------------
module rc4_key_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter bit CHECK_EN  = 1'b1,
    localparam int MSG_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic                   key_valid,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    input  logic [7:0]             s_q,
    output logic [MSG_W-1:0]       rom_addr,
    input  logic [7:0]             rom_q,
    output logic [MSG_W-1:0]       res_addr,
    output logic [7:0]             res_data,
    output logic                   res_wren
);

    localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [MSG_W-1:0]  K_LAST    = MSG_W'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        SH_RD_I, SH_LD_I, SH_RD_J, SH_LD_J, SH_WR_I, SH_WR_J,
        DE_RD_I, DE_LD_I, DE_RD_J, DE_LD_J, DE_WR_I, DE_WR_J, DE_RD_F, DE_LD_F,
        ST_DONE
    } state_e;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              key_valid_q;
    logic [7:0]        s_addr_q;
    logic [7:0]        s_data_q;
    logic              s_wren_q;
    logic [MSG_W-1:0]  rom_addr_q;
    logic [MSG_W-1:0]  res_addr_q;
    logic              res_wren_q;
    logic [7:0]        i_q;
    logic [7:0]        j_q;
    logic [MSG_W-1:0]  k_q;
    logic [KIDX_W-1:0] kidx_q;
    logic [7:0]        si_q;
    logic [7:0]        sj_q;

    logic [7:0]        key_byte;
    logic [7:0]        j_shuf_d;
    logic [7:0]        j_dec_d;
    logic [7:0]        decoded;
    logic              legal;

    // Selects the current key byte. The index comes from a wrapping counter,
    // so no i mod KEY_BYTES divider is needed.
    // NOTE: every always_comb output is assigned a default first, so a missed
    // branch cannot infer a latch.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KIDX_W'(b)) begin
                key_byte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    assign j_shuf_d = j_q + s_q + key_byte;
    assign j_dec_d  = j_q + s_q;
    assign decoded  = s_q ^ rom_q;
    assign legal    = ((decoded >= 8'h61) && (decoded <= 8'h7A)) || (decoded == 8'h20);

    // The keystream byte and the ciphertext byte both arrive in LD_F. The
    // decoded byte is therefore formed from the memory read data in that
    // cycle, and it is gated to zero whenever no write is in progress.
    assign res_data  = res_wren_q ? decoded : 8'h00;

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign s_addr    = s_addr_q;
    assign s_data    = s_data_q;
    assign s_wren    = s_wren_q;
    assign rom_addr  = rom_addr_q;
    assign res_addr  = res_addr_q;
    assign res_wren  = res_wren_q;

    // The outputs are registered. Each transition loads the values that the
    // state being entered must present. The S-memory itself is external and
    // is not cleared here, because every run rewrites it completely in INIT.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            s_addr_q    <= 8'h00;
            s_data_q    <= 8'h00;
            s_wren_q    <= 1'b0;
            rom_addr_q  <= '0;
            res_addr_q  <= '0;
            res_wren_q  <= 1'b0;
            i_q         <= 8'h00;
            j_q         <= 8'h00;
            k_q         <= '0;
            kidx_q      <= '0;
            si_q        <= 8'h00;
            sj_q        <= 8'h00;
        end else begin
            // Strobes are low unless the target state asserts them.
            done_q     <= 1'b0;
            s_wren_q   <= 1'b0;
            res_wren_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_INIT;
                        busy_q      <= 1'b1;
                        key_valid_q <= 1'b0;
                        i_q         <= 8'h00;
                        s_addr_q    <= 8'h00;
                        s_data_q    <= 8'h00;
                        s_wren_q    <= 1'b1;
                    end
                end

                ST_INIT: begin
                    if (i_q == 8'hFF) begin
                        state_q  <= SH_RD_I;
                        i_q      <= 8'h00;
                        j_q      <= 8'h00;
                        kidx_q   <= '0;
                        s_addr_q <= 8'h00;
                    end else begin
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                        s_data_q <= i_q + 8'd1;
                        s_wren_q <= 1'b1;
                    end
                end

                // ---------------- key schedule ----------------
                SH_RD_I: state_q <= SH_LD_I;

                SH_LD_I: begin
                    state_q  <= SH_RD_J;
                    si_q     <= s_q;
                    j_q      <= j_shuf_d;
                    s_addr_q <= j_shuf_d;
                    kidx_q   <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
                end

                SH_RD_J: state_q <= SH_LD_J;

                SH_LD_J: begin
                    state_q  <= SH_WR_I;
                    sj_q     <= s_q;
                    s_addr_q <= i_q;
                    s_data_q <= s_q;
                    s_wren_q <= 1'b1;
                end

                SH_WR_I: begin
                    state_q  <= SH_WR_J;
                    s_addr_q <= j_q;
                    s_data_q <= si_q;
                    s_wren_q <= 1'b1;
                end

                SH_WR_J: begin
                    if (i_q == 8'hFF) begin
                        // Enter DECRYPT with i already advanced for byte 0.
                        state_q  <= DE_RD_I;
                        i_q      <= 8'd1;
                        j_q      <= 8'h00;
                        k_q      <= '0;
                        s_addr_q <= 8'd1;
                    end else begin
                        state_q  <= SH_RD_I;
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                    end
                end

                // ---------------- keystream / decode ----------------
                DE_RD_I: state_q <= DE_LD_I;

                DE_LD_I: begin
                    state_q  <= DE_RD_J;
                    si_q     <= s_q;
                    j_q      <= j_dec_d;
                    s_addr_q <= j_dec_d;
                end

                DE_RD_J: state_q <= DE_LD_J;

                DE_LD_J: begin
                    state_q  <= DE_WR_I;
                    sj_q     <= s_q;
                    s_addr_q <= i_q;
                    s_data_q <= s_q;
                    s_wren_q <= 1'b1;
                end

                DE_WR_I: begin
                    state_q  <= DE_WR_J;
                    s_addr_q <= j_q;
                    s_data_q <= si_q;
                    s_wren_q <= 1'b1;
                end

                DE_WR_J: begin
                    state_q    <= DE_RD_F;
                    s_addr_q   <= si_q + sj_q;
                    rom_addr_q <= k_q;
                end

                DE_RD_F: begin
                    state_q    <= DE_LD_F;
                    res_addr_q <= k_q;
                    res_wren_q <= 1'b1;
                end

                DE_LD_F: begin
                    if (CHECK_EN && !legal) begin
                        // This byte is still written; the run stops here.
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b0;
                    end else if (k_q == K_LAST) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                    end else begin
                        state_q  <= DE_RD_I;
                        k_q      <= k_q + MSG_W'(1);
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
